// File: rtl/regfile_pkg.sv
// ============================================================================
//  Module   : regfile_pkg
//  Purpose  : Shared types and helpers for the multi-port register file.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    // Sweep controller states
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Widest data word the parity helper accepts; narrower words are zero-extended.
    localparam int c_PAR_MAX_W = 256;

    function automatic int DEPTH_OF(input int addrW);
        return 1 << addrW;
    endfunction

    function automatic logic par(input logic [c_PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_if.sv
// ============================================================================
//  Module   : regfile_if
//  Purpose  : Read/write port bundle of the register file (par_err only with
//             REGFILE_PARITY_EN).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [1:0]               wr_en;
    logic [ADDR_W-1:0]        wr_addr0;
    logic [ADDR_W-1:0]        wr_addr1;
    logic [DATA_W-1:0]        wr_data0;
    logic [DATA_W-1:0]        wr_data1;
    logic                     busy;
`ifdef REGFILE_PARITY_EN
    logic                     par_err;
`endif

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr0, wr_addr1, wr_data0, wr_data1,
`ifdef REGFILE_PARITY_EN
        input  par_err,
`endif
        input  rd_data, busy
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr0, wr_addr1, wr_data0, wr_data1,
`ifdef REGFILE_PARITY_EN
        output par_err,
`endif
        output rd_data, busy
    );

endinterface

`default_nettype wire

// File: rtl/regfile_rd_port.sv
// ============================================================================
//  Module   : regfile_rd_port
//  Purpose  : One registered read port: zero-register check, write-first bypass
//             mux, output register and (REGFILE_PARITY_EN) parity check.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_clearing,
    input  wire logic              i_rdEn,
    input  wire logic [ADDR_W-1:0] i_rdAddr,
    input  wire logic [DATA_W-1:0] i_entry,
`ifdef REGFILE_PARITY_EN
    input  wire logic              i_entryPar,
    output logic                   o_parFlag,
`endif
    input  wire logic [1:0]        i_wrEn,
    input  wire logic [ADDR_W-1:0] i_wrAddr0,
    input  wire logic [DATA_W-1:0] i_wrData0,
    input  wire logic [ADDR_W-1:0] i_wrAddr1,
    input  wire logic [DATA_W-1:0] i_wrData1,
    output logic [DATA_W-1:0]      o_rdData
);

    logic              w_isZero;
    logic              w_hit0;
    logic              w_hit1;
    logic [DATA_W-1:0] w_rdVal;
    logic [DATA_W-1:0] r_rdData;

    assign w_isZero = (ZERO_REG != 0) && (i_rdAddr == '0);
    assign w_hit1   = i_wrEn[1] && (i_wrAddr1 == i_rdAddr);
    assign w_hit0   = i_wrEn[0] && (i_wrAddr0 == i_rdAddr);

    // Port 1 outranks port 0 so the bypass agrees with what the array will hold.
    always_comb begin
        w_rdVal = i_entry;
        if (w_isZero) begin
            w_rdVal = '0;
        end else if (w_hit1) begin
            w_rdVal = i_wrData1;
        end else if (w_hit0) begin
            w_rdVal = i_wrData0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_clearing) begin
            r_rdData <= '0;
        end else if (i_rdEn) begin
            r_rdData <= w_rdVal;
        end
    end

    assign o_rdData = r_rdData;

`ifdef REGFILE_PARITY_EN
    // Only reads served from the array are checked; bypassed data never touched it.
    assign o_parFlag = !i_clearing && i_rdEn && !w_isZero && !w_hit0 && !w_hit1
                     && (par(c_PAR_MAX_W'(i_entry)) != i_entryPar);
`endif

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : NUM_RD-read / 2-write register file with write-first bypass,
//             optional hardwired zero entry and post-reset clear sweep.
//             Optional even parity per entry with macro REGFILE_PARITY_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    regfile_if.slave   bus
);

    localparam int DEPTH = DEPTH_OF(ADDR_W);

    state_t            r_state;
    logic [ADDR_W-1:0] r_clrCnt;
    logic              r_busy;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] w_rdData [NUM_RD];
    logic              w_wrOk0;
    logic              w_wrOk1;
    logic              w_clearing;

    assign w_clearing = (r_state == CLEAR);

    // Writes to entry 0 are dropped when it is hardwired to zero.
    assign w_wrOk0 = !w_clearing && bus.wr_en[0]
                   && !((ZERO_REG != 0) && (bus.wr_addr0 == '0));
    assign w_wrOk1 = !w_clearing && bus.wr_en[1]
                   && !((ZERO_REG != 0) && (bus.wr_addr1 == '0));

    // Sweep controller: reset parks at entry 0; each released edge clears one entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= CLEAR;
            r_clrCnt <= '0;
            r_busy   <= 1'b1;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_clrCnt <= r_clrCnt + 1'b1;
                    if (r_clrCnt == ADDR_W'(DEPTH - 1)) begin
                        r_state <= READY;
                        r_busy  <= 1'b0;
                    end
                end
                READY: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_state  <= CLEAR;
                    r_clrCnt <= '0;
                    r_busy   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;

    // Storage array; port 1 is written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_clearing) begin
                r_mem[r_clrCnt] <= '0;
            end else begin
                if (w_wrOk0) begin
                    r_mem[bus.wr_addr0] <= bus.wr_data0;
                end
                if (w_wrOk1) begin
                    r_mem[bus.wr_addr1] <= bus.wr_data1;
                end
            end
        end
    end

`ifdef REGFILE_PARITY_EN
    logic              r_par [DEPTH];
    logic              r_parErr;
    logic [NUM_RD-1:0] w_parFlag;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_clearing) begin
                r_par[r_clrCnt] <= 1'b0;
            end else begin
                if (w_wrOk0) begin
                    r_par[bus.wr_addr0] <= par(c_PAR_MAX_W'(bus.wr_data0));
                end
                if (w_wrOk1) begin
                    r_par[bus.wr_addr1] <= par(c_PAR_MAX_W'(bus.wr_data1));
                end
            end
        end
    end

    // Sticky until the next reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_parErr <= 1'b0;
        end else if (|w_parFlag) begin
            r_parErr <= 1'b1;
        end
    end

    assign bus.par_err = r_parErr;
`endif

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rdPort
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_entry;

        assign w_addr  = bus.rd_addr[gi*ADDR_W +: ADDR_W];
        assign w_entry = r_mem[w_addr];

        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rdPort (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_clearing (w_clearing),
            .i_rdEn     (bus.rd_en[gi]),
            .i_rdAddr   (w_addr),
            .i_entry    (w_entry),
`ifdef REGFILE_PARITY_EN
            .i_entryPar (r_par[w_addr]),
            .o_parFlag  (w_parFlag[gi]),
`endif
            .i_wrEn     (bus.wr_en),
            .i_wrAddr0  (bus.wr_addr0),
            .i_wrData0  (bus.wr_data0),
            .i_wrAddr1  (bus.wr_addr1),
            .i_wrData1  (bus.wr_data1),
            .o_rdData   (w_rdData[gi])
        );
    end

    always_comb begin
        bus.rd_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            bus.rd_data[i*DATA_W +: DATA_W] = w_rdData[i];
        end
    end

endmodule

`default_nettype wire
